// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stall bus bit 0 is PC, bit 5 is WB; a set bit holds that stage.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam stall_bus_t STALL_NONE = {STALL_W{NO_STOP}};
    localparam stall_bus_t STALL_MEM  = 6'b011111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_IF   = 6'b000011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The request furthest down the pipe wins; it freezes everything behind it.
    function automatic stall_bus_t stall_mask(input logic data_wait,
                                              input logic stallreq_ex,
                                              input logic stallreq_id,
                                              input logic inst_wait);
        stall_bus_t m;
        if (data_wait)        m = STALL_MEM;
        else if (stallreq_ex) m = STALL_EX;
        else if (stallreq_id) m = STALL_ID;
        else if (inst_wait)   m = STALL_IF;
        else                  m = STALL_NONE;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !sat)
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall merger and exception-flush sequencer with stall watchdog/statistics.
//  state    | meaning
//  ST_RUN   | normal operation, stall = merged request mask
//  ST_DRAIN | redirect latched, waiting for the data access to finish; fetch held
//  ST_FLUSH | one-cycle flush of IF..MEM, new_pc presented, no stall
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               inst_wait,
    input  logic               data_wait,
    input  logic               flush_req,
    input  logic [31:0]        flush_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               stall_timeout,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

    state_t             state;
    logic [31:0]        pc_q;
    logic               flush_q;
    stall_bus_t         stall_next;
    logic               stall_any;
    logic [RUN_W-1:0]   run_cnt;
    logic               run_sat;
    logic               cyc_sat;

    always_comb begin
        stall_next = STALL_NONE;
        case (state)
            ST_RUN:   stall_next = stall_mask(data_wait, stallreq_ex, stallreq_id, inst_wait);
            ST_DRAIN: stall_next = stall_mask(data_wait, stallreq_ex, stallreq_id, inst_wait) | STALL_IF;
            ST_FLUSH: stall_next = STALL_NONE;
            default:  stall_next = STALL_NONE;
        endcase
    end

    // The mask is combinational, so gate it with reset to keep stall at zero while held.
    assign stall     = rst ? stall_next : STALL_NONE;
    assign stall_any = |stall;
    assign flush     = flush_q;
    assign new_pc    = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            pc_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (flush_req) begin
                        pc_q <= flush_pc;
                        if (data_wait) begin
                            state   <= ST_DRAIN;
                            flush_q <= 1'b0;
                        end else begin
                            state   <= ST_FLUSH;
                            flush_q <= 1'b1;
                        end
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!data_wait) begin
                        state   <= ST_FLUSH;
                        flush_q <= 1'b1;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_req) begin
                        pc_q    <= flush_pc;
                        flush_q <= 1'b1;
                    end else begin
                        state   <= ST_RUN;
                        flush_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any & ~run_sat),
        .clr   (~stall_any | (state == ST_FLUSH)),
        .count (run_cnt),
        .sat   (run_sat)
    );

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any & ~cyc_sat),
        .clr   (1'b0),
        .count (stall_cycles),
        .sat   (cyc_sat)
    );

    // Fire on the edge that completes the STALL_TIMEOUT-th consecutive stalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_timeout <= 1'b0;
        else if (stall_any && (run_cnt >= RUN_W'(STALL_TIMEOUT - 1)))
            stall_timeout <= 1'b1;
    end

endmodule
